// File: rtl/imem_loader.sv
// Boot loader: NOP-fills instruction memory, then packs a little-endian byte stream into words.
// Holds the core in reset until the stream ends plus RST_HOLD cycles; all outputs registered.
module imem_loader #(
    parameter int          ADDR_W   = 9,
    parameter int          DEPTH    = 512,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013,
    parameter int          RST_HOLD = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_partial,
    output logic              err_overflow
);
    localparam int HCW = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {ST_CLEAR, ST_RECV, ST_HOLD, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [1:0]          idx_q, idx_d;
    logic [23:0]         asm_q, asm_d;
    logic [HCW-1:0]      hcnt_q, hcnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                core_rst_q, core_rst_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     wc_q, wc_d;
    logic                ep_q, ep_d;
    logic                eo_q, eo_d;
    logic                hs;

    assign hs = byte_valid && ready_q;

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        idx_d      = idx_q;
        asm_d      = asm_q;
        hcnt_d     = hcnt_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ready_d    = 1'b0;
        core_rst_d = 1'b1;
        done_d     = 1'b0;
        wc_d       = wc_q;
        ep_d       = ep_q;
        eo_d       = eo_q;
        case (state_q)
            ST_CLEAR: begin
                we_d      = 1'b1;
                addr_d    = clr_ptr_q;
                wdata_d   = NOP_WORD;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_RECV;
            end
            ST_RECV: begin
                ready_d = 1'b1;
                if (hs) begin
                    if (idx_q == 2'd3) begin
                        idx_d = 2'd0;
                        if (wc_q < (ADDR_W+1)'(DEPTH)) begin
                            we_d    = 1'b1;
                            addr_d  = wc_q[ADDR_W-1:0];
                            wdata_d = {byte_data, asm_q};
                            wc_d    = wc_q + 1'b1;
                        end else begin
                            eo_d = 1'b1;
                        end
                    end else begin
                        // Bytes enter at the top so b0 ends up in the low lane.
                        asm_d = {byte_data, asm_q[23:8]};
                        idx_d = idx_q + 1'b1;
                    end
                    if (byte_last) begin
                        if (idx_q != 2'd3) ep_d = 1'b1;
                        idx_d   = 2'd0;
                        hcnt_d  = '0;
                        ready_d = 1'b0;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (hcnt_q == HCW'(RST_HOLD)) begin
                    state_d    = ST_RUN;
                    core_rst_d = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: begin
                core_rst_d = 1'b0;
                done_d     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            idx_q      <= 2'd0;
            asm_q      <= '0;
            hcnt_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            wc_q       <= '0;
            ep_q       <= 1'b0;
            eo_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            hcnt_q     <= hcnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            wc_q       <= wc_d;
            ep_q       <= ep_d;
            eo_q       <= eo_d;
        end
    end

    assign byte_ready   = ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_rst     = core_rst_q;
    assign load_done    = done_q;
    assign word_count   = wc_q;
    assign err_partial  = ep_q;
    assign err_overflow = eo_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte table with expected writes plus hand-written corner sequences.
module tb_imem_loader;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       byte_ready;
    logic       imem_we;
    logic [8:0] imem_addr;
    logic [31:0] imem_wdata;
    logic       core_rst;
    logic       load_done;
    logic [9:0] word_count;
    logic       err_partial;
    logic       err_overflow;

    imem_loader dut (
        .clk(clk), .rst(rst),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst(core_rst), .load_done(load_done),
        .word_count(word_count), .err_partial(err_partial), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // Memory model fed from the write port, plus a write counter.
    logic [31:0] mem [512];
    logic        mem_clr = 1'b0;
    int          wr_cnt = 0;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'hDEAD_BEEF;
        end else if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
            wr_cnt         <= wr_cnt + 1;
        end
    end

    typedef struct {
        logic [7:0]  data;
        logic        exp_we;
        logic [31:0] exp_word;
    } vec_t;
    vec_t tbl [16];

    int tests = 0;
    int fails = 0;
    int stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        mem_clr    = 1'b1;
        tick();
        tick();
        mem_clr = 1'b0;
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", {23'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_wc", {22'd0, word_count}, 32'd0);
        chk("rst_errs", {30'd0, err_partial, err_overflow}, 32'd0);
        rst = 1'b1;
    endtask

    task automatic check_clear();
        int bad;
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            tick();
            if (imem_we !== 1'b1 || imem_addr !== 9'(k) || imem_wdata !== NOP || byte_ready !== 1'b0)
                bad++;
        end
        chk("clear_seq_bad_cycles", bad, 0);
        tick();
        chk("ready_after_clear", {31'd0, byte_ready}, 32'd1);
        chk("we_off_after_clear", {31'd0, imem_we}, 32'd0);
    endtask

    task automatic check_nop_from(input int first);
        int bad;
        bad = 0;
        for (int i = first; i < 512; i++) if (mem[i] !== NOP) bad++;
        chk("mem_nop_words_bad", bad, 0);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
        logic hs;
        int   n;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            tick();
        end
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = last;
        n = 0;
        do begin
            hs = byte_ready;
            tick();
            n++;
        end while (!hs && n < 50);
        if (!hs) chk("handshake_timeout", 32'd0, 32'd1);
        stalls += n - 1;
    endtask

    task automatic run_table(input int n, input logic with_last, input logic gapped);
        for (int i = 0; i < n; i++) begin
            send_byte(tbl[i].data, with_last && (i == n - 1), gapped ? int'($urandom_range(0, 2)) : 0);
            chk("tbl_we", {31'd0, imem_we}, {31'd0, tbl[i].exp_we});
            if (tbl[i].exp_we) begin
                chk("tbl_addr", {23'd0, imem_addr}, i / 4);
                chk("tbl_wdata", imem_wdata, tbl[i].exp_word);
            end
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    // Caller is one cycle past the last handshake; release lands 11 cycles after it.
    task automatic check_hold();
        int bad;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (core_rst !== 1'b1 || load_done !== 1'b0 || imem_we !== 1'b0 || byte_ready !== 1'b0)
                bad++;
        end
        chk("hold_cycles_bad", bad, 0);
        tick();
        chk("core_rst_released", {31'd0, core_rst}, 32'd0);
        chk("load_done_set", {31'd0, load_done}, 32'd1);
    endtask

    initial begin
        int wr0;
        tbl[0]  = '{8'h13, 1'b0, 32'h0};
        tbl[1]  = '{8'h05, 1'b0, 32'h0};
        tbl[2]  = '{8'h10, 1'b0, 32'h0};
        tbl[3]  = '{8'h00, 1'b1, 32'h0010_0513};
        tbl[4]  = '{8'h93, 1'b0, 32'h0};
        tbl[5]  = '{8'h05, 1'b0, 32'h0};
        tbl[6]  = '{8'h20, 1'b0, 32'h0};
        tbl[7]  = '{8'h00, 1'b1, 32'h0020_0593};
        tbl[8]  = '{8'h13, 1'b0, 32'h0};
        tbl[9]  = '{8'h06, 1'b0, 32'h0};
        tbl[10] = '{8'h30, 1'b0, 32'h0};
        tbl[11] = '{8'h00, 1'b1, 32'h0030_0613};
        tbl[12] = '{8'h93, 1'b0, 32'h0};
        tbl[13] = '{8'h06, 1'b0, 32'h0};
        tbl[14] = '{8'h40, 1'b0, 32'h0};
        tbl[15] = '{8'h00, 1'b1, 32'h0040_0693};
        stalls = 0;

        // Clear, then basic 8-byte back-to-back load.
        do_reset();
        check_clear();
        check_nop_from(0);
        run_table(8, 1'b1, 1'b0);
        check_hold();
        chk("basic_wc", {22'd0, word_count}, 32'd2);
        chk("basic_mem0", mem[0], 32'h0010_0513);
        chk("basic_mem1", mem[1], 32'h0020_0593);
        check_nop_from(2);
        chk("basic_errs", {30'd0, err_partial, err_overflow}, 32'd0);
        byte_valid = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        byte_valid = 1'b0;
        chk("run_ignores_valid", {22'd0, word_count}, 32'd2);
        chk("run_ready_low", {31'd0, byte_ready}, 32'd0);

        // Gapped 16-byte stream.
        do_reset();
        check_clear();
        run_table(16, 1'b1, 1'b1);
        check_hold();
        chk("gap_wc", {22'd0, word_count}, 32'd4);
        chk("gap_mem3", mem[3], 32'h0040_0693);
        chk("gap_mem0", mem[0], 32'h0010_0513);
        check_nop_from(4);

        // Partial tail: 6 bytes.
        do_reset();
        check_clear();
        run_table(6, 1'b1, 1'b0);
        check_hold();
        chk("part_wc", {22'd0, word_count}, 32'd1);
        chk("part_err_partial", {31'd0, err_partial}, 32'd1);
        chk("part_err_overflow", {31'd0, err_overflow}, 32'd0);
        chk("part_mem1_nop", mem[1], NOP);

        // Overflow: 2052 bytes, 513 words.
        do_reset();
        check_clear();
        wr0    = wr_cnt;
        stalls = 0;
        for (int i = 0; i < 2052; i++) send_byte(8'(i), i == 2051, 0);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        check_hold();
        chk("ovf_writes", wr_cnt - wr0, 512);
        chk("ovf_stalls", stalls, 0);
        chk("ovf_wc", {22'd0, word_count}, 32'd512);
        chk("ovf_err_overflow", {31'd0, err_overflow}, 32'd1);
        chk("ovf_err_partial", {31'd0, err_partial}, 32'd0);
        chk("ovf_mem1", mem[1], 32'h0706_0504);
        chk("ovf_mem511", mem[511], 32'hFFFE_FDFC);

        // Mid-load reset after 3 words plus a stray byte.
        do_reset();
        check_clear();
        run_table(13, 1'b0, 1'b0);
        chk("mid_wc_before", {22'd0, word_count}, 32'd3);
        do_reset();
        check_clear();
        check_nop_from(0);
        chk("mid_wc_after", {22'd0, word_count}, 32'd0);
        run_table(4, 1'b1, 1'b0);
        check_hold();
        chk("mid_no_stale_partial", {31'd0, err_partial}, 32'd0);
        chk("mid_mem0", mem[0], 32'h0010_0513);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader that sits directly upstream of the OoO core's instruction memory. It fills all 512 words with NOP, accepts a little-endian byte stream over a valid/ready handshake, and assembles each group of four bytes into a 32-bit word written to consecutive word addresses. It holds the core in reset until loading completes plus a fixed hold interval. This replaces backdoor memory preloading with a synthesizable path.

## Interface
- ADDR_W, 9, word-address width of instruction memory
- DEPTH, 512, number of words (2**ADDR_W)
- NOP_WORD, 32'h00000013, fill value for every word before loading
- RST_HOLD, 10, cycles `core_rst` stays high after the last write

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- byte_valid  in  1  stream byte present
- byte_data  in  8  stream byte (byte 0 of a word arrives first)
- byte_last  in  1  final byte of stream; qualified by handshake
- byte_ready  out  1  loader accepts byte this cycle
- imem_we  out  1  instruction-memory write enable
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  write data
- core_rst  out  1  active-high reset to core
- load_done  out  1  loading finished, core running
- word_count  out  ADDR_W+1  words written from stream (0..DEPTH)
- err_partial  out  1  stream ended mid-word (sticky)
- err_overflow  out  1  bytes arrived beyond DEPTH words (sticky)

## Operation
- All outputs are registered. Reset (rst=0 at a clk edge) sets: state CLEAR, clear pointer 0, byte index 0, imem_we=0, imem_addr=0, imem_wdata=0, byte_ready=0, core_rst=1, load_done=0, word_count=0, both error flags 0.
- A handshake is `byte_valid && byte_ready` at a clk edge.
- FSM states:
  - CLEAR: imem_we=1, imem_wdata=NOP_WORD, imem_addr counts 0..DEPTH-1, one word per cycle. After writing address DEPTH-1, go to RECV.
  - RECV: byte_ready=1. Shift bytes into an assembly register: `{b3,b2,b1,b0}`, with b0 the first byte. On the 4th handshake:
    - If word_count<DEPTH: next cycle imem_we=1, imem_addr=word_count[ADDR_W-1:0], imem_wdata=assembled word, then word_count increments.
    - If word_count==DEPTH: discard the word and set err_overflow.
    - On a handshake with byte_last=1:
      - If it completes a word, write that word, then go to HOLD.
      - Otherwise discard the partial bytes, set err_partial, and go to HOLD.
  - HOLD: byte_ready=0, imem_we=0, core_rst=1. Count RST_HOLD cycles, then go to RUN.
  - RUN: core_rst=0, load_done=1, byte_ready=0. This state is terminal until reset.
- The byte index wraps 3→0 after each complete word. word_count saturates at DEPTH.
- Reset at any point, including mid-CLEAR or mid-word, aborts to CLEAR. Memory is fully refilled with NOP and the partial word is lost.
- A zero-length stream is not possible; at least one byte carries byte_last.

## Timing
- CLEAR occupies exactly DEPTH cycles. imem_we is high from the first edge after rst rises through edge DEPTH.
- byte_ready rises on the cycle after the last CLEAR write.
- Byte-accept latency is 0: the byte is taken on the handshake edge. The word write appears 1 cycle after the 4th handshake.
- Sustained rate is 1 byte per cycle, so one word is written every 4 cycles.
- The HOLD entry cycle follows the byte_last handshake. If a word write is pending from that handshake, it occurs in the first HOLD cycle.
- core_rst falls and load_done rises exactly RST_HOLD+1 cycles after the byte_last handshake.
- byte_valid without ready (during CLEAR, HOLD, or RUN) is ignored. No byte is lost or double-counted.

## Test plan
- Clear: release rst, send nothing. Expect imem_we for 512 cycles with addr 0..511 and data 0x00000013. Expect byte_ready=1 at cycle 513 and memory all NOP.
- Basic load: stream bytes 13,05,10,00, 93,05,20,00 with last on the 8th byte. Expect writes 0x00100513@0 and 0x00200593@1 and word_count=2. Expect load_done=1 and core_rst=0 exactly 11 cycles after the last handshake; words 2..511 remain NOP.
- Gapped stream: toggle byte_valid randomly for 16 bytes. Expect the same 4 words as the back-to-back case, with writes only on cycles following each 4th handshake.
- Partial tail: send 6 bytes with last on the 6th. Expect 1 word written, err_partial=1, word_count=1, and address 1 still NOP.
- Overflow: send 2052 bytes with last at the end. Expect 512 writes, err_overflow=1, word_count=512, and byte_ready stays 1 until last.
- Mid-load reset: assert rst=0 after 3 words are loaded. Expect all outputs at reset values, then a full 512-cycle NOP refill, word_count=0, and errors cleared.
